// File: rtl/dither_multichannel_pkg.sv
// Shared types, the 2x2 ordered-dither matrix and the add/shift/saturate helper
// used by every colour channel of the dither block.
package dither_pkg;

  typedef enum logic [1:0] {
    DM_TRUNC   = 2'd0,
    DM_ROUND   = 2'd1,
    DM_DIFFUSE = 2'd2,
    DM_BAYER   = 2'd3
  } dither_mode_t;

  // Indexed [row parity][column parity]
  localparam logic [1:0] BAYER [2][2] = '{'{2'd0, 2'd2}, '{2'd3, 2'd1}};

  localparam int SUM_W = 16;

  function automatic logic [SUM_W-1:0] sat_shift(input logic [SUM_W-1:0] a,
                                                 input logic [SUM_W-1:0] b,
                                                 input int unsigned      sh,
                                                 input logic [SUM_W-1:0] lim);
    logic [SUM_W-1:0] r;
    r = (a + b) >> sh;
    return (r > lim) ? lim : r;
  endfunction

endpackage

// File: rtl/dither_multichannel_if.sv
// Pixel-in / dithered-pixel-out bundle between the pixel source and the DAC stage.
interface dither_multichannel_if
  import dither_pkg::*;
#(
  parameter int N_CH  = 3,
  parameter int IN_W  = 8,
  parameter int OUT_W = 4
) ();

  dither_mode_t            mode;
  logic                    in_valid;
  logic                    in_visible;
  logic                    in_frame_start;
  logic [N_CH*IN_W-1:0]    in_pix;
  logic                    out_valid;
  logic                    out_visible;
  logic [N_CH*OUT_W-1:0]   out_pix;

  modport master (
    output mode, in_valid, in_visible, in_frame_start, in_pix,
    input  out_valid, out_visible, out_pix
  );

  modport slave (
    input  mode, in_valid, in_visible, in_frame_start, in_pix,
    output out_valid, out_visible, out_pix
  );

endinterface

// File: rtl/dither_multichannel_channel.sv
// One colour channel: depth reduction in the selected mode plus the
// carried diffusion error, both registered on accepted pixels.
module dither_channel
  import dither_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4,
  localparam int D    = IN_W - OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  v,
  input  dither_mode_t     mode,
  input  logic [D-1:0]     bayer_off,
  input  logic             load,
  input  logic             clear_err,
  output logic [OUT_W-1:0] out
);

  localparam logic [SUM_W-1:0] MAXO = SUM_W'((1 << OUT_W) - 1);
  localparam logic [SUM_W-1:0] HALF = SUM_W'(1 << (D - 1));

  logic [D-1:0]     err;
  logic [D-1:0]     err_nxt;
  logic [OUT_W-1:0] out_nxt;
  logic [IN_W:0]    s;

  always_comb begin
    out_nxt = '0;
    err_nxt = '0;
    s       = (IN_W+1)'(v) + (IN_W+1)'(err);
    case (mode)
      DM_TRUNC:   out_nxt = v[IN_W-1:D];
      DM_ROUND:   out_nxt = OUT_W'(sat_shift(SUM_W'(v), HALF, D, MAXO));
      DM_DIFFUSE: begin
        // Overflow saturates and drops the residual instead of carrying it
        if (s[IN_W]) begin
          out_nxt = OUT_W'(MAXO);
        end else begin
          out_nxt = s[IN_W-1:D];
          err_nxt = s[D-1:0];
        end
      end
      DM_BAYER:   out_nxt = OUT_W'(sat_shift(SUM_W'(v), SUM_W'(bayer_off), D, MAXO));
      default:    out_nxt = '0;
    endcase
    if (clear_err) begin
      out_nxt = '0;
      err_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
      err <= '0;
    end else if (load) begin
      out <= out_nxt;
      err <= err_nxt;
    end
  end

endmodule

// File: rtl/dither_multichannel.sv
// Multi-channel colour-depth reducer: valid/visible pipeline, dither
// position parities and one dither_channel per colour.
module dither_multichannel
  import dither_pkg::*;
#(
  parameter int N_CH  = 3,
  parameter int IN_W  = 8,
  parameter int OUT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  dither_multichannel_if.slave  bus
);

  localparam int D = IN_W - OUT_W;

  generate
    if (D < 2) begin : g_bad_d
      $error("dither_multichannel: IN_W-OUT_W must be at least 2");
    end
    if (IN_W >= SUM_W) begin : g_bad_w
      $error("dither_multichannel: IN_W too wide for sat_shift");
    end
  endgenerate

  logic                   out_valid_r;
  logic                   out_visible_r;
  logic                   x_par;
  logic                   y_par;
  logic                   xp_eff;
  logic                   yp_eff;
  logic [D-1:0]           bay_off;
  logic                   clear_err;
  logic [N_CH*OUT_W-1:0]  pix_out;

  // Frame start resets the dither position before this pixel uses it
  always_comb begin
    xp_eff    = bus.in_frame_start ? 1'b0 : x_par;
    yp_eff    = bus.in_frame_start ? 1'b0 : y_par;
    bay_off   = D'(BAYER[yp_eff][xp_eff]) << (D - 2);
    clear_err = ~bus.in_visible;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r   <= 1'b0;
      out_visible_r <= 1'b0;
      x_par         <= 1'b0;
      y_par         <= 1'b0;
    end else begin
      out_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        out_visible_r <= bus.in_visible;
        x_par         <= bus.in_visible ? ~xp_eff : 1'b0;
        // out_visible_r holds the previous accepted pixel's visibility
        y_par         <= (out_visible_r & ~bus.in_visible) ? ~yp_eff : yp_eff;
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    dither_channel #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .v         (bus.in_pix[c*IN_W +: IN_W]),
      .mode      (bus.mode),
      .bayer_off (bay_off),
      .load      (bus.in_valid),
      .clear_err (clear_err),
      .out       (pix_out[c*OUT_W +: OUT_W])
    );
  end

  assign bus.out_valid   = out_valid_r;
  assign bus.out_visible = out_visible_r;
  assign bus.out_pix     = pix_out;

endmodule

// File: tb/tb_dither_multichannel.sv
// Scoreboard bench: a reference model pushes expected outputs per cycle,
// a monitor pops and compares them one cycle later.
module tb_dither_multichannel;
  import dither_pkg::*;

  localparam int N_CH  = 3;
  localparam int IN_W  = 8;
  localparam int OUT_W = 4;

  typedef struct {
    bit          v;
    logic [11:0] pix;
    bit          vis;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t q[$];

  int          m_err[N_CH];
  bit          m_xp, m_yp, m_pv, m_lv;
  logic [11:0] m_lp;

  dither_multichannel_if #(.N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  dither_multichannel #(.N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  task automatic model(input bit r, input bit v, input int m, input bit vis,
                       input bit fs, input logic [23:0] pix, output exp_t e);
    int bay[2][2] = '{'{0, 2}, '{3, 1}};
    int vv, o, ne, s, xp, yp;
    logic [11:0] po;
    if (r) begin
      foreach (m_err[c]) m_err[c] = 0;
      m_xp = 0; m_yp = 0; m_pv = 0; m_lv = 0; m_lp = '0;
      e = '{v: 1'b0, pix: 12'h000, vis: 1'b0};
      return;
    end
    if (!v) begin
      e = '{v: 1'b0, pix: m_lp, vis: m_lv};
      return;
    end
    xp = fs ? 0 : int'(m_xp);
    yp = fs ? 0 : int'(m_yp);
    po = '0;
    for (int c = 0; c < N_CH; c++) begin
      vv = int'(pix[c*8 +: 8]);
      ne = 0;
      case (m)
        0: o = vv >> 4;
        1: begin o = (vv + 8) >> 4; if (o > 15) o = 15; end
        2: begin
          s = vv + m_err[c];
          if (s > 255) o = 15;
          else begin o = s >> 4; ne = s % 16; end
        end
        default: begin o = (vv + (bay[yp][xp] << 2)) >> 4; if (o > 15) o = 15; end
      endcase
      if (!vis) begin o = 0; ne = 0; end
      m_err[c] = ne;
      po[c*4 +: 4] = 4'(o);
    end
    if (m_pv && !vis) yp = 1 - yp;
    m_xp = vis ? (xp == 0) : 1'b0;
    m_yp = (yp != 0);
    m_pv = vis;
    m_lv = vis;
    m_lp = po;
    e = '{v: 1'b1, pix: po, vis: vis};
  endtask

  // Drives one cycle at the falling edge and queues what should appear after the next rise
  task automatic cyc(input bit r, input bit v, input int m, input bit vis,
                     input bit fs, input logic [23:0] pix);
    exp_t e;
    rst                = r;
    bus.in_valid       = v;
    bus.mode           = dither_mode_t'(m[1:0]);
    bus.in_visible     = vis;
    bus.in_frame_start = fs;
    bus.in_pix         = pix;
    model(r, v, m, vis, fs, pix, e);
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out_valid", 32'(bus.out_valid), 32'(e.v));
        chk("out_pix", 32'(bus.out_pix), 32'(e.pix));
        chk("out_visible", 32'(bus.out_visible), 32'(e.vis));
      end
    end
  end

  initial begin
    int wait_cnt;
    // reset with a pixel pending, then first pixel
    cyc(1, 1, 0, 1, 0, 24'hFFFFFF);
    cyc(1, 1, 0, 1, 0, 24'hFFFFFF);
    cyc(0, 1, 0, 1, 0, 24'hFFFFFF);
    // truncate and round
    cyc(0, 1, 0, 1, 0, 24'h3CA57F);
    cyc(0, 1, 1, 1, 0, 24'h07F078);
    cyc(0, 1, 1, 1, 0, 24'h8017F9);
    // diffusion, small value
    for (int i = 0; i < 4; i++) cyc(0, 1, 2, 1, 0, 24'h101818);
    cyc(0, 1, 2, 0, 0, 24'h101818);
    cyc(0, 1, 2, 1, 0, 24'h101818);
    // diffusion with saturation and an idle gap
    cyc(0, 1, 2, 0, 0, 24'h000000);
    cyc(0, 1, 2, 1, 0, 24'hFCFCFC);
    for (int i = 0; i < 3; i++) cyc(0, 0, 2, 1, 0, 24'h123456);
    cyc(0, 1, 2, 1, 0, 24'hFCFCFC);
    cyc(0, 1, 2, 1, 0, 24'hFCFCFC);
    // ordered dither across two lines and a frame start
    cyc(0, 1, 3, 1, 1, 24'h0A0A0A);
    cyc(0, 1, 3, 1, 0, 24'h0A0A0A);
    cyc(0, 1, 3, 0, 0, 24'h0A0A0A);
    cyc(0, 1, 3, 1, 0, 24'h0A0A0A);
    cyc(0, 1, 3, 1, 0, 24'h0A0A0A);
    cyc(0, 1, 3, 1, 1, 24'h0A0A0A);
    // mode switch clears pending error
    cyc(0, 1, 2, 1, 0, 24'h181818);
    cyc(0, 1, 0, 1, 0, 24'h181818);
    cyc(0, 1, 2, 1, 0, 24'h181818);
    // reset mid-line
    cyc(0, 1, 2, 1, 0, 24'h181818);
    cyc(1, 1, 3, 1, 1, 24'hFFFFFF);
    cyc(0, 1, 2, 1, 0, 24'h181818);
    // random traffic
    for (int i = 0; i < 200; i++)
      cyc(0, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
          ($urandom_range(0, 7) != 0), ($urandom_range(0, 31) == 0),
          24'($urandom()));
    wait_cnt = 0;
    while (q.size() != 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dither_multichannel.md
Name: dither_multichannel

Overview:
- Parametrised multi-channel colour-depth reducer for the VGA output path.
- Sits between the frame-buffer/serial pixel source and the DAC pins.
- Reduces N_CH channels of IN_W bits to OUT_W bits each.
- Four run-time modes: truncate, round, 1-D error diffusion (per-channel error carried pixel-to-pixel), 2x2 ordered (Bayer) dither.
- Has a valid qualifier and registered, 1-cycle-latency outputs.

Parameters:
- N_CH, 3, number of colour channels packed in the pixel word.
- IN_W, 8, input bits per channel.
- OUT_W, 4, output bits per channel; D = IN_W-OUT_W, D >= 2 required (elaboration assertion).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  0=truncate, 1=round, 2=error diffusion, 3=Bayer 2x2; sampled on every accepted pixel.
- in_valid  in  1  pixel present this cycle.
- in_visible  in  1  pixel inside active video area.
- in_frame_start  in  1  one-cycle pulse at first pixel of frame; clears row parity.
- in_pix  in  N_CH*IN_W  channel c at bits [c*IN_W +: IN_W].
- out_valid  out  1  registered copy of in_valid.
- out_visible  out  1  registered in_visible, updated only on accepted pixels.
- out_pix  out  N_CH*OUT_W  dithered pixel, channel c at [c*OUT_W +: OUT_W].

Behaviour:
- Reset: out_valid=0, out_visible=0, out_pix=0, all channel errors=0, x_par=0, y_par=0.
- Accepted pixel = in_valid high. Latency 1 cycle: output registers load at that clk edge.
- in_valid low: out_valid goes 0 next cycle; out_pix, out_visible, errors and parities hold.
- Accepted pixel with in_visible low: out_pix=0, all errors cleared, x_par cleared.
- Falling edge of in_visible (previous accepted visible=1, current=0): toggles y_par.
- in_frame_start on an accepted pixel: forces y_par=0 and x_par=0 before that pixel is processed.
- Per channel, v = input channel value, maxo = 2^OUT_W-1. All sums are IN_W+1 bits wide.
- Mode 0: out = v[IN_W-1:D]; error forced 0.
- Mode 1: out = min((v + 2^(D-1)) >> D, maxo); error forced 0.
- Mode 2: s = v + err (err is D bits, unsigned).
  - If s > 2^IN_W-1: out=maxo, err_next=0 (saturation discards the residual).
  - Else: out = s[IN_W-1:D], err_next = s[D-1:0].
- Mode 3: offset = B[y_par][x_par] << (D-2), with B = {{0,2},{3,1}}; out = min((v+offset)>>D, maxo); error forced 0.
- x_par toggles after each accepted visible pixel.
- Mode switching takes effect on the next accepted pixel; a non-diffusion mode clears the errors the same cycle.
- Channels are fully independent; errors are never shared between channels.
- Reset mid-line dominates all other inputs.

Decomposition:
- Package dither_pkg:
  - enum dither_mode_t {DM_TRUNC, DM_ROUND, DM_DIFFUSE, DM_BAYER}.
  - 2x2 Bayer constant matrix.
  - function sat_shift (add, shift, saturate).
- Sub-module dither_channel: one channel's datapath plus its D-bit error register, with ports v, mode, bayer offset, load, clear_err, out. Generated N_CH times.
- Top level holds the valid/visible pipeline, x_par/y_par and edge detection.

Test Plan (N_CH=3, IN_W=8, OUT_W=4):
- Reset with in_valid=1: out_valid=0, out_pix=0x000; first post-reset pixel 0xFFFFFF in mode 0 -> out_pix=0xFFF, out_valid=1 one cycle later.
- Mode 0 ch0=0x7F -> 0x7. Mode 1: ch0=0x78 -> 0x8; ch0=0xF9 -> 0xF (saturated).
- Mode 2, ch0 constant 0x18, 4 visible pixels -> outputs 1,2,1,2. Then one accepted pixel with visible=0 (out 0), then 0x18 -> out 1 (error was cleared).
- Mode 2, ch0 constant 0xFC -> outputs F,F,F with errors C,0,C; in_valid gap of 3 cycles between pixels 1 and 2 does not change the sequence.
- Mode 3, ch0=0x0A:
  - Line0 x0,x1 -> 0,1.
  - visible low, then line1 x0,x1 -> 1,0.
  - in_frame_start on the next pixel -> 0 (row0 col0).
- Mode switch 2->0 mid-line with err=8 pending, then back to 2 with 0x18 -> first output 1, not 2.
